// File: rtl/button_debounce_edge_if.sv
// Channel bundle for the debouncer: raw inputs in, clean level and edge pulses out.
// dbg_state carries each channel's FSM state, two bits per channel, channel 0 in the LSBs.
`timescale 1ns/1ps
interface button_debounce_edge_if #(
  parameter int par_N_channels = 4
);
  logic [par_N_channels-1:0]   i_raw;
  logic [par_N_channels-1:0]   o_level;
  logic [par_N_channels-1:0]   o_rise;
  logic [par_N_channels-1:0]   o_fall;
  logic [2*par_N_channels-1:0] dbg_state;

  // No handshake: i_raw is sampled every clock; o_level/o_rise/o_fall are registered
  // and valid every cycle; o_rise/o_fall are single-cycle strobes.
  modport master (
    output i_raw,
    input  o_level,
    input  o_rise,
    input  o_fall,
    input  dbg_state
  );

  modport slave (
    input  i_raw,
    output o_level,
    output o_rise,
    output o_fall,
    output dbg_state
  );
endinterface

// File: rtl/button_debounce_edge.sv
// Multi-channel push-button debouncer: 2-FF synchronizer, hold-time qualifying FSM
// and registered level / rise / fall outputs per channel.
`timescale 1ns/1ps
module button_debounce_edge #(
  parameter int par_N_channels      = 4,
  parameter int par_T_debounce_val  = 4,
  parameter int par_T_debounce_bits = $clog2(par_T_debounce_val)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  button_debounce_edge_if.slave bus
);
  localparam logic [1:0] ST_LO     = 2'd0;
  localparam logic [1:0] ST_CHK_HI = 2'd1;
  localparam logic [1:0] ST_HI     = 2'd2;
  localparam logic [1:0] ST_CHK_LO = 2'd3;

  localparam int unsigned T_LAST = par_T_debounce_val - 1;
  localparam logic [par_T_debounce_bits-1:0] T_MAX = T_LAST[par_T_debounce_bits-1:0];

  logic [par_N_channels-1:0]   level_d;
  logic [par_N_channels-1:0]   rise_d;
  logic [par_N_channels-1:0]   fall_d;
  logic [par_N_channels-1:0]   level_q;
  logic [par_N_channels-1:0]   rise_q;
  logic [par_N_channels-1:0]   fall_q;
  logic [2*par_N_channels-1:0] state_vec;

  for (genvar g = 0; g < par_N_channels; g++) begin : g_ch
    logic                           s1;
    logic                           s_x;
    logic [1:0]                     state;
    logic [1:0]                     state_nx;
    logic [par_T_debounce_bits-1:0] timer;

    always_comb begin
      state_nx = state;
      case (state)
        ST_LO:     if (s_x) state_nx = ST_CHK_HI;
        ST_CHK_HI: begin
          if (!s_x)                state_nx = ST_LO;
          else if (timer == T_MAX) state_nx = ST_HI;
        end
        ST_HI:     if (!s_x) state_nx = ST_CHK_LO;
        ST_CHK_LO: begin
          if (s_x)                 state_nx = ST_HI;
          else if (timer == T_MAX) state_nx = ST_LO;
        end
        default:   state_nx = ST_LO;
      endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s1    <= 1'b0;
        s_x   <= 1'b0;
        state <= ST_LO;
        timer <= '0;
      end else begin
        s1    <= bus.i_raw[g];
        s_x   <= s1;
        state <= state_nx;
        // Timer measures time spent in the current state; it only matters in the CHK states.
        if (state_nx != state)  timer <= '0;
        else if (timer != T_MAX) timer <= timer + 1'b1;
      end
    end

    // Outputs are registered from the next state so they change on the transition edge itself.
    assign level_d[g] = (state_nx == ST_HI) || (state_nx == ST_CHK_LO);
    assign rise_d[g]  = (state == ST_CHK_HI) && (state_nx == ST_HI);
    assign fall_d[g]  = (state == ST_CHK_LO) && (state_nx == ST_LO);
    assign state_vec[2*g +: 2] = state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.o_level   = level_q;
  assign bus.o_rise    = rise_q;
  assign bus.o_fall    = fall_q;
  assign bus.dbg_state = state_vec;
endmodule

// File: tb/tb_button_debounce_edge.sv
// Bench for button_debounce_edge: directed scenarios plus randomized bouncing inputs,
// every cycle compared against a consecutive-sample-count reference model.
`timescale 1ns/1ps
module tb_button_debounce_edge;
  localparam int N = 4;
  localparam int T = 4;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  button_debounce_edge_if #(.par_N_channels(N)) bus ();

  button_debounce_edge #(
    .par_N_channels     (N),
    .par_T_debounce_val (T)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a channel's level flips once the synchronized input has
  // disagreed with it for T+1 consecutive samples.
  logic [N-1:0] s1_m, s2_m, lvl_m, rise_m, fall_m;
  int           cnt_m [N];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_m <= '0; s2_m <= '0; lvl_m <= '0; rise_m <= '0; fall_m <= '0;
      for (int i = 0; i < N; i++) cnt_m[i] <= 0;
    end else begin
      s1_m <= bus.i_raw;
      s2_m <= s1_m;
      for (int i = 0; i < N; i++) begin
        rise_m[i] <= 1'b0;
        fall_m[i] <= 1'b0;
        if (s2_m[i] != lvl_m[i]) begin
          if (cnt_m[i] + 1 == T + 1) begin
            lvl_m[i]  <= s2_m[i];
            rise_m[i] <= s2_m[i];
            fall_m[i] <= ~s2_m[i];
            cnt_m[i]  <= 0;
          end else begin
            cnt_m[i] <= cnt_m[i] + 1;
          end
        end else begin
          cnt_m[i] <= 0;
        end
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("level", 32'(bus.o_level), 32'(lvl_m));
      check("rise",  32'(bus.o_rise),  32'(rise_m));
      check("fall",  32'(bus.o_fall),  32'(fall_m));
      check("excl",  32'(bus.o_rise & bus.o_fall), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
  endtask

  // Runs n edges, recording first pulse position (1-based, -1 if none) and pulse counts.
  task automatic scan(input int ch, input int n, output int fr, output int nr,
                      output int ff, output int nf);
    fr = -1; nr = 0; ff = -1; nf = 0;
    for (int e = 1; e <= n; e++) begin
      tick(1);
      if (bus.o_rise[ch]) begin nr++; if (fr < 0) fr = e; end
      if (bus.o_fall[ch]) begin nf++; if (ff < 0) ff = e; end
    end
  endtask

  task automatic async_reset_check(input string tag);
    i_rst_n = 1'b0;
    #1;
    check(tag, 32'(bus.o_level | bus.o_rise | bus.o_fall), 32'd0);
  endtask

  int fr, nr, ff, nf, sr, sf;
  int hold [N];
  logic [N-1:0] r;

  initial begin
    bus.i_raw = 4'hF;
    i_rst_n   = 1'b0;
    #2;
    check("rst_level", 32'(bus.o_level), 32'd0);
    check("rst_rise",  32'(bus.o_rise),  32'd0);
    check("rst_fall",  32'(bus.o_fall),  32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);

    @(negedge i_clk);
    bus.i_raw = '0;
    i_rst_n   = 1'b1;
    chk_en    = 1'b1;
    tick(20);
    check("idle_level", 32'(bus.o_level), 32'd0);

    // Clean press and release on channel 0.
    bus.i_raw[0] = 1'b1;
    scan(0, 12, fr, nr, ff, nf);
    check("press_edge", fr, 7);
    check("press_cnt",  nr, 1);
    check("press_fall", nf, 0);
    check("press_lvl",  32'(bus.o_level[0]), 32'd1);
    bus.i_raw[0] = 1'b0;
    scan(0, 12, fr, nr, ff, nf);
    check("release_edge", ff, 7);
    check("release_cnt",  nf, 1);
    check("release_rise", nr, 0);
    check("release_lvl",  32'(bus.o_level[0]), 32'd0);

    // Channel 1: four samples high is a glitch, five is accepted.
    bus.i_raw[1] = 1'b1;
    scan(1, 4, fr, nr, ff, nf);  sr = nr; sf = nf;
    bus.i_raw[1] = 1'b0;
    scan(1, 16, fr, nr, ff, nf); sr += nr; sf += nf;
    check("glitch4_rise", sr, 0);
    check("glitch4_fall", sf, 0);
    bus.i_raw[1] = 1'b1;
    scan(1, 5, fr, nr, ff, nf);  sr = nr; sf = nf;
    bus.i_raw[1] = 1'b0;
    scan(1, 20, fr, nr, ff, nf); sr += nr; sf += nf;
    check("hold5_rise", sr, 1);
    check("hold5_fall", sf, 1);

    // Channel 2 bounces 1,0,1,0 then settles at 1.
    sr = 0;
    for (int b = 0; b < 4; b++) begin
      bus.i_raw[2] = (b % 2 == 0);
      scan(2, 1, fr, nr, ff, nf);
      sr += nr;
    end
    check("bounce_early", sr, 0);
    bus.i_raw[2] = 1'b1;
    scan(2, 14, fr, nr, ff, nf);
    check("bounce_edge", fr, 7);
    check("bounce_cnt",  nr, 1);
    bus.i_raw[2] = 1'b0;
    tick(12);

    // Channel 3: reset lands mid-qualification, input stays high through it.
    bus.i_raw[3] = 1'b1;
    tick(4);
    async_reset_check("midchk_rst");
    tick(2);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    scan(3, 14, fr, nr, ff, nf);
    check("requal_edge", fr, 7);
    check("requal_cnt",  nr, 1);
    #2;
    async_reset_check("hi_rst_async");
    bus.i_raw = '0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick(4);

    // All channels at once.
    bus.i_raw = 4'hF;
    tick(7);
    check("simul_rise",  32'(bus.o_rise),  32'hF);
    tick(1);
    check("simul_after", 32'(bus.o_rise),  32'h0);
    check("simul_level", 32'(bus.o_level), 32'hF);
    bus.i_raw = 4'h0;
    tick(12);

    // Randomized bouncing with occasional resets.
    r = '0;
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 12);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          r[i]    = ~r[i];
          hold[i] = $urandom_range(1, 2 * T + 3);
        end else begin
          hold[i]--;
        end
      end
      bus.i_raw = r;
      if (!i_rst_n) i_rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) async_reset_check("rand_rst");
      tick(1);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
